// File: rtl/exp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exp_ctrl_pkg
//   Shared definitions for the EXP series-expansion controller:
//   FSM state encoding, term-index width, Q2.8 fixed-point constants and the
//   default number of terms generated per x value.
// -----------------------------------------------------------------------------
package exp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_EMIT = 3'd2,
        ST_STEP = 3'd3,
        ST_WAIT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam int         KW          = 4;        // width of k / dp_k / k_out
    localparam int         FRAC        = 8;        // fractional bits of a term (Q2.8)
    localparam logic [9:0] ONE         = 10'h100;  // 1.0 in Q2.8
    localparam int         EXP_N_TERMS = 10;       // terms emitted per x

endpackage

// File: rtl/exp_x_fifo.sv
// -----------------------------------------------------------------------------
// exp_x_fifo
//   Small synchronous FIFO holding the x values waiting to be expanded.
//   A push into a full FIFO or a pop from an empty one is dropped.
//   Simultaneous push and pop keep the count; the head seen during that cycle
//   is the old head.
// Ports
//   clk, reset   clock (rising edge), asynchronous active-high reset
//   push, din    write din at the tail
//   pop          drop the head entry
//   dout         current head entry (valid when empty=0)
//   full, empty  occupancy flags
//   count        number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module exp_x_fifo #(
    parameter  int W     = 2,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/exp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// exp_seq_ctrl
//   Control FSM for the EXP series-expansion datapath. Queues incoming x
//   values, then for each x loads term=1.0 (dp_init) and runs N_TERMS-1
//   multiply/divide steps (dp_start / dp_done), emitting every term as a
//   registered output strobe. finish rises with the last term of the N_X-th x.
// Ports
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   datain, input_valid     x offer; accepted when busy=0
//   busy                    input not accepted this cycle
//   dp_init, dp_start       one-cycle datapath command pulses
//   dp_x, dp_k              datapath operands (current x, divisor k)
//   dp_done, dp_term        datapath completion pulse and current term
//   dataout, k_out          emitted term and its index
//   output_valid            one-cycle strobe for dataout/k_out
//   finish                  all N_X values expanded; held until reset
// -----------------------------------------------------------------------------
module exp_seq_ctrl
    import exp_ctrl_pkg::*;
#(
    parameter int XW      = 2,
    parameter int DW      = 10,
    parameter int N_TERMS = EXP_N_TERMS,
    parameter int N_X     = 4,
    parameter int QDEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] datain,
    input  logic          input_valid,
    output logic          busy,
    output logic          dp_init,
    output logic          dp_start,
    output logic [XW-1:0] dp_x,
    output logic [KW-1:0] dp_k,
    input  logic          dp_done,
    input  logic [DW-1:0] dp_term,
    output logic [DW-1:0] dataout,
    output logic [KW-1:0] k_out,
    output logic          output_valid,
    output logic          finish
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int AW = $clog2(N_X + 1);

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [KW-1:0] k_q, k_d;
    logic [AW-1:0] accepted_q, accepted_d;
    logic [AW-1:0] done_cnt_q, done_cnt_d;
    logic [DW-1:0] dataout_q, dataout_d;
    logic [KW-1:0] k_out_q, k_out_d;
    logic          valid_q, valid_d;

    logic          push, pop;
    logic          q_full, q_empty;
    logic [CW-1:0] q_count;
    logic [XW-1:0] q_head;

    exp_x_fifo #(
        .W     (XW),
        .DEPTH (QDEPTH)
    ) u_x_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (datain),
        .pop   (pop),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Purely register-derived, so it drops to 0 the moment reset clears the flops.
    assign busy = (q_count == CW'(QDEPTH)) || (accepted_q == AW'(N_X)) ||
                  (state_q == ST_DONE);
    assign push = input_valid && !busy && !q_full;

    assign dp_x         = x_q;
    assign dp_k         = k_q;
    assign dataout      = dataout_q;
    assign k_out        = k_out_q;
    assign output_valid = valid_q;
    // DONE is entered on the same edge that raises the last output_valid.
    assign finish       = (state_q == ST_DONE);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        k_d        = k_q;
        accepted_d = accepted_q;
        done_cnt_d = done_cnt_q;
        dataout_d  = dataout_q;
        k_out_d    = k_out_q;
        valid_d    = 1'b0;
        pop        = 1'b0;
        dp_init    = 1'b0;
        dp_start   = 1'b0;

        if (push) accepted_d = accepted_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    pop     = 1'b1;
                    x_d     = q_head;
                    k_d     = '0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                dp_init = 1'b1;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                dataout_d = dp_term;
                k_out_d   = k_q;
                valid_d   = 1'b1;
                if (k_q < KW'(N_TERMS - 1)) begin
                    k_d     = k_q + 1'b1;
                    state_d = ST_STEP;
                end else begin
                    done_cnt_d = done_cnt_q + 1'b1;
                    if (done_cnt_q == AW'(N_X - 1)) begin
                        state_d = ST_DONE;
                    end else if (!q_empty) begin
                        // Chain straight into the next x without an IDLE bubble.
                        pop     = 1'b1;
                        x_d     = q_head;
                        k_d     = '0;
                        state_d = ST_INIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STEP: begin
                dp_start = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                // dp_done is only meaningful here; stray pulses elsewhere are ignored.
                if (dp_done) state_d = ST_EMIT;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            k_q        <= '0;
            accepted_q <= '0;
            done_cnt_q <= '0;
            dataout_q  <= '0;
            k_out_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            k_q        <= k_d;
            accepted_q <= accepted_d;
            done_cnt_q <= done_cnt_d;
            dataout_q  <= dataout_d;
            k_out_q    <= k_out_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_exp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exp_seq_ctrl
//   Two controller instances (queue depth 4 and 2), each paired with a
//   behavioural datapath whose dp_done latency is programmable. Expected
//   terms and datapath commands are queued when an x is accepted and
//   compared as the controller produces them.
// -----------------------------------------------------------------------------
module tb_exp_seq_ctrl;
    import exp_ctrl_pkg::*;

    localparam int XW    = 2;
    localparam int DW    = 10;
    localparam int NT    = 10;
    localparam int NX    = 4;
    localparam int NU    = 2;
    localparam int TOTAL = NT * NX;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [KW-1:0] k;
        logic [DW-1:0] term;
    } exp_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [KW-1:0] k;
    } st_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NU-1:0] input_valid, busy, dp_init, dp_start, dp_done, output_valid, finish;
    logic [XW-1:0] datain  [NU];
    logic [XW-1:0] dp_x    [NU];
    logic [KW-1:0] dp_k    [NU];
    logic [KW-1:0] k_out   [NU];
    logic [DW-1:0] dp_term [NU];
    logic [DW-1:0] dataout [NU];

    wire [31:0] out_cnt   [NU];
    wire [31:0] init_cnt  [NU];
    wire [31:0] start_cnt [NU];
    wire [31:0] acc_cnt   [NU];
    wire        saw_bp    [NU];

    int            lat         = 1;     // dp_done latency L in WAIT cycles
    logic          stray_en    = 1'b0;
    logic [NU-1:0] stray_idle  = '0;
    logic          chk_spacing = 1'b0;
    logic          chk_lat     = 1'b0;
    int            cyc         = 0;

    int n_checks = 0;
    int n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] next_term(input logic [DW-1:0] t, input logic [XW-1:0] x,
                                                input int unsigned k);
        int unsigned p;
        p = (32'(t) * 32'(x)) / k;
        return p[DW-1:0];
    endfunction

    for (genvar gi = 0; gi < NU; gi++) begin : g_unit
        exp_seq_ctrl #(
            .XW(XW), .DW(DW), .N_TERMS(NT), .N_X(NX), .QDEPTH(gi == 0 ? 4 : 2)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .datain       (datain[gi]),
            .input_valid  (input_valid[gi]),
            .busy         (busy[gi]),
            .dp_init      (dp_init[gi]),
            .dp_start     (dp_start[gi]),
            .dp_x         (dp_x[gi]),
            .dp_k         (dp_k[gi]),
            .dp_done      (dp_done[gi]),
            .dp_term      (dp_term[gi]),
            .dataout      (dataout[gi]),
            .k_out        (k_out[gi]),
            .output_valid (output_valid[gi]),
            .finish       (finish[gi])
        );

        // Behavioural datapath: term = term * x / k, dp_done after lat cycles.
        logic [DW-1:0] m_term_q;
        logic          m_done_q, m_prev_done_q, m_prev_init_q;
        int            m_cnt_q;
        logic [XW-1:0] m_x_q;
        logic [KW-1:0] m_k_q;

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                m_term_q      <= '0;
                m_done_q      <= 1'b0;
                m_prev_done_q <= 1'b0;
                m_prev_init_q <= 1'b0;
                m_cnt_q       <= 0;
                m_x_q         <= '0;
                m_k_q         <= '0;
            end else begin
                m_done_q      <= 1'b0;
                m_prev_done_q <= m_done_q;
                m_prev_init_q <= dp_init[gi];
                if (dp_init[gi]) m_term_q <= ONE;
                if (dp_start[gi]) begin
                    m_x_q <= dp_x[gi];
                    m_k_q <= dp_k[gi];
                    if (lat <= 1) begin
                        m_done_q <= 1'b1;
                        m_term_q <= next_term(m_term_q, dp_x[gi], dp_k[gi]);
                    end else begin
                        m_cnt_q <= lat - 1;
                    end
                end else if (m_cnt_q != 0) begin
                    m_cnt_q <= m_cnt_q - 1;
                    if (m_cnt_q == 1) begin
                        m_done_q <= 1'b1;
                        m_term_q <= next_term(m_term_q, m_x_q, m_k_q);
                    end
                end
            end
        end

        assign dp_term[gi] = m_term_q;
        // Stray pulses land in INIT, STEP and the EMIT cycles (never in WAIT).
        assign dp_done[gi] = m_done_q | stray_idle[gi] |
                             (stray_en & (dp_init[gi] | dp_start[gi] | m_prev_done_q | m_prev_init_q));

        // Scoreboard / monitor
        exp_t exp_q[$];
        st_t  st_q[$];
        exp_t e;
        st_t  s;
        logic [DW-1:0] t;
        int   out_l, init_l, start_l, acc_l, last_ov, last_acc;
        logic bp_l;

        assign out_cnt[gi]   = out_l;
        assign init_cnt[gi]  = init_l;
        assign start_cnt[gi] = start_l;
        assign acc_cnt[gi]   = acc_l;
        assign saw_bp[gi]    = bp_l;

        always @(negedge clk) begin
            if (reset) begin
                exp_q.delete();
                st_q.delete();
                out_l    <= 0;
                init_l   <= 0;
                start_l  <= 0;
                acc_l    <= 0;
                bp_l     <= 1'b0;
                last_ov  <= 0;
                last_acc <= 0;
            end else begin
                if (input_valid[gi] && !busy[gi]) begin
                    acc_l    <= acc_l + 1;
                    last_acc <= cyc + 1;
                    t = ONE;
                    for (int k = 0; k < NT; k++) begin
                        if (k > 0) begin
                            t = next_term(t, datain[gi], k);
                            st_q.push_back({datain[gi], KW'(k)});
                        end
                        exp_q.push_back({datain[gi], KW'(k), t});
                    end
                end
                if (busy[gi] && acc_l < NX) bp_l <= 1'b1;
                if (dp_init[gi]) init_l <= init_l + 1;
                if (dp_start[gi]) begin
                    start_l <= start_l + 1;
                    if (st_q.size() == 0) begin
                        check_val("dp_start_unexpected", 32'd1, 32'd0);
                    end else begin
                        s = st_q.pop_front();
                        check_val("dp_x", 32'(dp_x[gi]), 32'(s.x));
                        check_val("dp_k", 32'(dp_k[gi]), 32'(s.k));
                    end
                end
                if (output_valid[gi]) begin
                    $display("unit %0d: term k=%0d dataout=%03h finish=%0d", gi, k_out[gi],
                             dataout[gi], finish[gi]);
                    if (exp_q.size() == 0) begin
                        check_val("output_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("k_out", 32'(k_out[gi]), 32'(e.k));
                        check_val("dataout", 32'(dataout[gi]), 32'(e.term));
                    end
                    check_val("finish_at_output", 32'(finish[gi]), 32'(out_l + 1 == TOTAL));
                    if (chk_spacing && k_out[gi] != '0)
                        check_val("term_spacing", cyc - last_ov, 2 + lat);
                    if (chk_lat && k_out[gi] == '0)
                        check_val("first_latency", cyc - last_acc, 3);
                    last_ov <= cyc;
                    out_l   <= out_l + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic send_x(input int u, input logic [XW-1:0] x);
        input_valid[u] = 1'b1;
        datain[u]      = x;
        check_val("busy_at_offer", 32'(busy[u]), 32'd0);
        tick();
        input_valid[u] = 1'b0;
    endtask

    task automatic wait_outs(input int u, input int target, input int budget);
        for (int i = 0; i < budget && int'(out_cnt[u]) < target; i++) tick();
        check_val("output_count", out_cnt[u], target);
    endtask

    logic found;
    int   ic;

    initial begin
        input_valid = '0;
        for (int u = 0; u < NU; u++) datain[u] = '0;
        reset = 1'b1;
        tick();
        tick();
        for (int u = 0; u < NU; u++)
            check_val("reset_outputs", 32'({busy[u], dp_init[u], dp_start[u], output_valid[u],
                      finish[u], dp_x[u], dp_k[u], k_out[u], dataout[u]}), 32'd0);
        reset = 1'b0;
        tick();

        // Single x=2, L=3: spacing 5, first output 3 cycles after accept
        lat         = 3;
        chk_spacing = 1'b1;
        chk_lat     = 1'b1;
        send_x(0, 2'd2);
        wait_outs(0, NT, 300);
        chk_spacing = 1'b0;
        chk_lat     = 1'b0;
        check_val("t1_init_count", init_cnt[0], 1);
        check_val("t1_start_count", start_cnt[0], NT - 1);
        check_val("t1_pending", g_unit[0].exp_q.size(), 0);
        check_val("t1_finish_low", 32'(finish[0]), 32'd0);

        // Stray dp_done pulses outside WAIT
        do_reset();
        lat           = 2;
        stray_en      = 1'b1;
        stray_idle[0] = 1'b1;
        tick();
        tick();
        tick();
        stray_idle[0] = 1'b0;
        check_val("t4_idle_no_output", out_cnt[0], 0);
        check_val("t4_idle_no_init", init_cnt[0], 0);
        send_x(0, 2'd1);
        wait_outs(0, NT, 300);
        stray_en = 1'b0;
        check_val("t4_start_count", start_cnt[0], NT - 1);
        check_val("t4_pending", g_unit[0].exp_q.size(), 0);

        // x=0..3 back to back, L=1, full run to finish
        do_reset();
        lat = 1;
        for (int x = 0; x < NX; x++) send_x(0, XW'(x));
        check_val("t2_busy_after_4", 32'(busy[0]), 32'd1);
        wait_outs(0, TOTAL, 800);
        check_val("t2_finish", 32'(finish[0]), 32'd1);
        repeat (5) tick();
        check_val("t2_finish_held", 32'(finish[0]), 32'd1);
        check_val("t2_pending", g_unit[0].exp_q.size(), 0);

        // input_valid while in DONE
        ic = init_cnt[0];
        for (int i = 0; i < 3; i++) begin
            input_valid[0] = 1'b1;
            datain[0]      = 2'd2;
            check_val("t6_busy", 32'(busy[0]), 32'd1);
            check_val("t6_finish", 32'(finish[0]), 32'd1);
            tick();
        end
        input_valid[0] = 1'b0;
        tick();
        tick();
        check_val("t6_no_init", init_cnt[0], ic);
        check_val("t6_no_accept", acc_cnt[0], NX);

        // Depth-2 queue with input_valid held, x=3
        do_reset();
        input_valid[1] = 1'b1;
        datain[1]      = 2'd3;
        for (int i = 0; i < 300 && int'(acc_cnt[1]) < NX; i++) tick();
        input_valid[1] = 1'b0;
        check_val("t3_accepts", acc_cnt[1], NX);
        check_val("t3_backpressure", 32'(saw_bp[1]), 32'd1);
        wait_outs(1, TOTAL, 800);
        check_val("t3_finish", 32'(finish[1]), 32'd1);
        check_val("t3_pending", g_unit[1].exp_q.size(), 0);

        // Reset during WAIT at k=5 of x=1
        do_reset();
        lat = 3;
        send_x(0, 2'd1);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (dp_start[0] && dp_k[0] == 4'd5 && dp_x[0] == 2'd1) found = 1'b1;
        end
        check_val("t5_reached_k5", 32'(found), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        check_val("t5_outputs_in_reset", 32'({busy[0], dp_init[0], dp_start[0], output_valid[0],
                  finish[0], dp_x[0], dp_k[0], k_out[0], dataout[0]}), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_val("t5_busy_after_release", 32'(busy[0]), 32'd0);
        lat = 1;
        send_x(0, 2'd1);
        wait_outs(0, NT, 300);
        check_val("t5_pending", g_unit[0].exp_q.size(), 0);
        check_val("t5_start_count", start_cnt[0], NT - 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
